// File: rtl/mem_pkg.sv
// Shared constants, state encoding and lane-select helpers for the MEM-stage
// access controller.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } state_e;

  // Size 2'b11 decodes as a word, so only size[1] matters for word checks.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    if (size[1]) begin
      mis = (lo != 2'b00);
    end else if (size == SZ_HALF) begin
      mis = lo[0];
    end
    return mis;
  endfunction

  // Bit offset of the byte lane addressed by lo.
  function automatic logic [4:0] byte_shift(input logic [1:0] lo, input logic big_endian);
    logic [1:0] lane;
    lane = lo ^ {2{big_endian}};
    return {lane, 3'b000};
  endfunction

  // Bit offset of the halfword lane addressed by lo[1].
  function automatic logic [4:0] half_shift(input logic lo1, input logic big_endian);
    logic lane;
    lane = lo1 ^ big_endian;
    return {lane, 4'b0000};
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword lane of a memory word and extends it
// to 32 bits for the MEM/WB register.
module load_align
  import mem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [4:0]  bsel;
  logic [4:0]  hsel;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    bsel     = byte_shift(addr_lo, BIG_ENDIAN);
    hsel     = half_shift(addr_lo[1], BIG_ENDIAN);
    byte_val = rdata[bsel +: 8];
    half_val = rdata[hsel +: 16];
    result   = rdata;
    if (size == SZ_BYTE) begin
      result = is_unsigned ? {24'b0, byte_val} : {{24{byte_val[7]}}, byte_val};
    end else if (size == SZ_HALF) begin
      result = is_unsigned ? {16'b0, half_val} : {{16{half_val[15]}}, half_val};
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory controller: word-wide accesses, read-modify-write for
// partial stores, load alignment/extension and misalignment detection.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter bit          BIG_ENDIAN = 1'b0,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic              memread_i,
  input  logic              memwrite_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [31:0]       mem_rdata_i,
  output logic [31:0]       load_data_o,
  output logic              stall_o,
  output logic              misalign_o
);

  state_e      state_q;
  logic [31:0] merge_q;

  logic        is_store;
  logic        is_load;
  logic        misaligned;
  logic        partial;
  logic [4:0]  bsel;
  logic [4:0]  hsel;
  logic [31:0] merged;
  logic [31:0] aligned_data;

  // A simultaneous read+write request is a store.
  assign is_store   = memwrite_i;
  assign is_load    = memread_i & ~memwrite_i;
  assign misaligned = (is_store | is_load) & is_misaligned(size_i, addr_i[1:0]);
  assign partial    = is_store & ~size_i[1];

  always_comb begin
    bsel   = byte_shift(addr_i[1:0], BIG_ENDIAN);
    hsel   = half_shift(addr_i[1], BIG_ENDIAN);
    merged = mem_rdata_i;
    if (size_i == SZ_BYTE) begin
      merged[bsel +: 8] = wdata_i[7:0];
    end else begin
      merged[hsel +: 16] = wdata_i[15:0];
    end
  end

  load_align #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_load_align (
    .rdata      (mem_rdata_i),
    .addr_lo    (addr_i[1:0]),
    .size       (size_i),
    .is_unsigned(unsigned_i),
    .result     (aligned_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      merge_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (partial && !misaligned) begin
            state_q <= ST_RMW_WR;
            merge_q <= merged;
          end
        end
        ST_RMW_WR: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  // Reset gates every enable so an in-flight RMW write is dropped at once.
  always_comb begin
    mem_addr_o  = {addr_i[ADDR_W-1:2], 2'b00};
    mem_wdata_o = wdata_i;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    stall_o     = 1'b0;
    misalign_o  = 1'b0;
    load_data_o = '0;
    if (!reset) begin
      unique case (state_q)
        ST_IDLE: begin
          if (misaligned) begin
            misalign_o = 1'b1;
          end else if (is_load) begin
            mem_read_o  = 1'b1;
            load_data_o = aligned_data;
          end else if (is_store) begin
            if (partial) begin
              mem_read_o = 1'b1;
              stall_o    = 1'b1;
            end else begin
              mem_write_o = 1'b1;
            end
          end
        end
        ST_RMW_WR: begin
          mem_write_o = 1'b1;
          mem_wdata_o = merge_q;
        end
        default: ;
      endcase
    end
  end

endmodule
